// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles every non-clock signal of the memory port arbiter. It carries the
// instruction-cache request, the data-cache request and write-beat handshake,
// the read-return path, and the single 4-byte main-memory port.
//   slave  : the arbiter's side (takes requests and memory status, drives the
//            memory command and the read returns).
//   master : the surrounding caches and memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH       = 17,
  parameter int DATA_LEN         = 32,
  parameter int ENTRY_INDEX_SIZE = 3
);
  // instruction cache
  logic                          i_req;
  logic [ADDR_WIDTH-1:0]         i_addr;
  logic [ENTRY_INDEX_SIZE:0]     i_length;
  logic                          i_done;
  // data cache
  logic                          d_req;
  logic                          d_we;
  logic [ADDR_WIDTH-1:0]         d_addr;
  logic [ENTRY_INDEX_SIZE:0]     d_length;
  logic [DATA_LEN-1:0]           d_wdata;
  logic [2:0]                    d_data_type;
  logic [ENTRY_INDEX_SIZE-1:0]   d_beat_idx;
  logic                          d_done;
  // shared read return
  logic [DATA_LEN-1:0]           rdata;
  logic                          rdata_valid;
  logic [ENTRY_INDEX_SIZE-1:0]   beat_idx;
  // main-memory port
  logic [1:0]                    mem_vis_signal;
  logic [ADDR_WIDTH-1:0]         mem_vis_addr;
  logic [DATA_LEN-1:0]           mem_written_data;
  logic [2:0]                    mem_data_type;
  logic [DATA_LEN-1:0]           mem_data;
  logic [1:0]                    mem_status;

  modport slave (
    input  i_req, i_addr, i_length,
    input  d_req, d_we, d_addr, d_length, d_wdata, d_data_type,
    input  mem_data, mem_status,
    output i_done, d_done, d_beat_idx,
    output rdata, rdata_valid, beat_idx,
    output mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type
  );

  modport master (
    output i_req, i_addr, i_length,
    output d_req, d_we, d_addr, d_length, d_wdata, d_data_type,
    output mem_data, mem_status,
    input  i_done, d_done, d_beat_idx,
    input  rdata, rdata_valid, beat_idx,
    input  mem_vis_signal, mem_vis_addr, mem_written_data, mem_data_type
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one 4-byte main-memory port between the instruction cache and the
// data cache. One burst is granted at a time, split into 4-byte beats and
// issued one beat per ISSUE/WAIT round trip. Read beats are handed back on
// rdata/rdata_valid/beat_idx. Data requests win arbitration unless the
// instruction side has already waited through MAX_D_STREAK data grants.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : mem_port_arbiter_if.slave (requests, read return, memory port)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrate; a grant latches owner, base, length, we, type
// ISSUE   | one cycle: memory command for the current beat is driven
// WAIT    | wait for the owner's completion code on mem_status
// FINISH  | owner's done pulse is high; back to IDLE next cycle
module mem_port_arbiter #(
  parameter int ADDR_WIDTH       = 17,
  parameter int DATA_LEN         = 32,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int MAX_D_STREAK     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] MEM_NOP           = 2'd0;
  localparam logic [1:0] MEM_READ          = 2'd1;
  localparam logic [1:0] MEM_WRITE         = 2'd2;
  localparam logic [1:0] MEM_INST_FINISHED = 2'd1;
  localparam logic [1:0] MEM_DATA_FINISHED = 2'd2;

  localparam int LEN_W    = ENTRY_INDEX_SIZE + 1;
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t                      state_q, state_d;
  logic                        own_d_q, own_d_d;     // 1 = data cache owns the port
  logic                        we_q, we_d;
  logic [ADDR_WIDTH-1:0]       base_q, base_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic [2:0]                  dtype_q, dtype_d;
  logic [LEN_W-1:0]            beat_q, beat_d;
  logic [STREAK_W-1:0]         streak_q, streak_d;
  logic [1:0]                  vis_signal_q, vis_signal_d;
  logic [ADDR_WIDTH-1:0]       vis_addr_q, vis_addr_d;
  logic [2:0]                  mem_dtype_q, mem_dtype_d;
  logic [DATA_LEN-1:0]         rdata_q, rdata_d;
  logic                        rdata_valid_q, rdata_valid_d;
  logic [ENTRY_INDEX_SIZE-1:0] beat_idx_q, beat_idx_d;
  logic                        i_done_q, i_done_d;
  logic                        d_done_q, d_done_d;

  logic       grant_d;
  logic       grant_i;
  logic [1:0] expect_status;

  always_comb begin
    state_d       = state_q;
    own_d_d       = own_d_q;
    we_d          = we_q;
    base_d        = base_q;
    len_d         = len_q;
    dtype_d       = dtype_q;
    beat_d        = beat_q;
    streak_d      = streak_q;
    rdata_d       = rdata_q;
    beat_idx_d    = beat_idx_q;
    rdata_valid_d = 1'b0;
    i_done_d      = 1'b0;
    d_done_d      = 1'b0;
    vis_signal_d  = MEM_NOP;
    vis_addr_d    = '0;
    mem_dtype_d   = '0;

    // Streak saturates at MAX_D_STREAK: once there, a waiting fetch wins.
    grant_d       = bus.d_req && !(bus.i_req && (streak_q == STREAK_MAX));
    grant_i       = !grant_d && bus.i_req;
    expect_status = own_d_q ? MEM_DATA_FINISHED : MEM_INST_FINISHED;

    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          own_d_d = 1'b1;
          we_d    = bus.d_we;
          base_d  = bus.d_addr;
          len_d   = (bus.d_length == '0) ? LEN_W'(1) : bus.d_length;
          dtype_d = bus.d_data_type;
          if (streak_q != STREAK_MAX) streak_d = streak_q + STREAK_W'(1);
        end else if (grant_i) begin
          own_d_d  = 1'b0;
          we_d     = 1'b0;
          base_d   = bus.i_addr;
          len_d    = (bus.i_length == '0) ? LEN_W'(1) : bus.i_length;
          dtype_d  = '0;
          streak_d = '0;
        end
        if (grant_d || grant_i) begin
          beat_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.mem_status == expect_status) begin
          if (!we_q) begin
            rdata_d       = bus.mem_data;
            beat_idx_d    = beat_q[ENTRY_INDEX_SIZE-1:0];
            rdata_valid_d = 1'b1;
          end
          beat_d = beat_q + LEN_W'(1);
          if (beat_d == len_q) begin
            state_d  = S_FINISH;
            i_done_d = !own_d_q;
            d_done_d = own_d_q;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Memory command is registered, so it is computed for the cycle the FSM
    // will spend in ISSUE; on a grant this uses the values being latched.
    if (state_d == S_ISSUE) begin
      vis_signal_d = (own_d_d && we_d) ? MEM_WRITE : MEM_READ;
      vis_addr_d   = base_d + ADDR_WIDTH'({beat_d, 2'b00});
      mem_dtype_d  = (own_d_d && we_d) ? dtype_d : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      own_d_q       <= 1'b0;
      we_q          <= 1'b0;
      base_q        <= '0;
      len_q         <= '0;
      dtype_q       <= '0;
      beat_q        <= '0;
      streak_q      <= '0;
      vis_signal_q  <= MEM_NOP;
      vis_addr_q    <= '0;
      mem_dtype_q   <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      beat_idx_q    <= '0;
      i_done_q      <= 1'b0;
      d_done_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      own_d_q       <= own_d_d;
      we_q          <= we_d;
      base_q        <= base_d;
      len_q         <= len_d;
      dtype_q       <= dtype_d;
      beat_q        <= beat_d;
      streak_q      <= streak_d;
      vis_signal_q  <= vis_signal_d;
      vis_addr_q    <= vis_addr_d;
      mem_dtype_q   <= mem_dtype_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      beat_idx_q    <= beat_idx_d;
      i_done_q      <= i_done_d;
      d_done_q      <= d_done_d;
    end
  end

  assign bus.mem_vis_signal = vis_signal_q;
  assign bus.mem_vis_addr   = vis_addr_q;
  assign bus.mem_data_type  = mem_dtype_q;
  assign bus.rdata          = rdata_q;
  assign bus.rdata_valid    = rdata_valid_q;
  assign bus.beat_idx       = beat_idx_q;
  assign bus.i_done         = i_done_q;
  assign bus.d_done         = d_done_q;
  // The data cache answers d_beat_idx within the same cycle, so the write
  // word is passed straight through while the write command is on the port.
  assign bus.d_beat_idx       = beat_q[ENTRY_INDEX_SIZE-1:0];
  assign bus.mem_written_data = (vis_signal_q == MEM_WRITE) ? bus.d_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW = 17;
  localparam int DW = 32;
  localparam int EIS = 3;
  localparam int MAXS = 4;
  localparam logic [1:0] MEM_NOP = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2;
  localparam logic [1:0] MEM_RESTING = 2'd0, MEM_INST_FINISHED = 2'd1, MEM_DATA_FINISHED = 2'd2;
  localparam logic [2:0] ONE_BYTE = 3'd0, TWO_BYTE = 3'd1, FOUR_BYTE = 3'd2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_LEN(DW), .ENTRY_INDEX_SIZE(EIS)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_LEN(DW), .ENTRY_INDEX_SIZE(EIS), .MAX_D_STREAK(MAXS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // data cache: write word per beat index, answered combinationally
  logic [DW-1:0] wdata_tbl [8];
  assign bus.d_wdata = wdata_tbl[bus.d_beat_idx];

  int n_checks = 0;
  int n_pass   = 0;
  int mdl_streak = 0;          // data grants since the last instruction grant
  bit owner_is_d = 1'b0;       // who memory believes it is serving
  bit force_noise = 1'b0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E3779B1) + 32'h0123_4567;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- monitor ----------------
  typedef struct packed {
    logic [1:0]     sig;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [2:0]     dtype;
    logic [EIS-1:0] dbi;
  } issue_t;
  typedef struct packed {
    logic [EIS-1:0] idx;
    logic [DW-1:0]  data;
  } rv_t;
  issue_t iss_q[$];
  rv_t    rv_q[$];
  int i_done_cnt = 0;
  int d_done_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_vis_signal != MEM_NOP)
        iss_q.push_back('{bus.mem_vis_signal, bus.mem_vis_addr, bus.mem_written_data,
                          bus.mem_data_type, bus.d_beat_idx});
      if (bus.rdata_valid) rv_q.push_back('{bus.beat_idx, bus.rdata});
      if (bus.i_done) i_done_cnt++;
      if (bus.d_done) d_done_cnt++;
    end
  end

  // ---------------- memory responder ----------------
  initial begin : responder
    logic [AW-1:0] a;
    int dly;
    bit noise;
    bit own;
    bus.mem_status = MEM_RESTING;
    bus.mem_data   = '0;
    forever begin
      @(negedge clk);
      bus.mem_status = MEM_RESTING;
      bus.mem_data   = '0;
      if (rst_n && bus.mem_vis_signal != MEM_NOP) begin
        a     = bus.mem_vis_addr;
        own   = owner_is_d;
        dly   = $urandom_range(0, 2);
        noise = force_noise || ($urandom_range(0, 3) == 0);
        repeat (dly + 1) @(negedge clk);
        if (noise) begin
          bus.mem_status = own ? MEM_INST_FINISHED : MEM_DATA_FINISHED;
          bus.mem_data   = ~mem_word(a);
          @(negedge clk);
        end
        bus.mem_status = own ? MEM_DATA_FINISHED : MEM_INST_FINISHED;
        bus.mem_data   = mem_word(a);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_any_done(output bit got, output bit was_d);
    got = 1'b0;
    was_d = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.i_done || bus.d_done) begin
        got = 1'b1;
        was_d = bus.d_done;
        break;
      end
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, ":vis_signal"}, 64'(bus.mem_vis_signal), 64'(MEM_NOP));
    chk({tag, ":vis_addr"}, 64'(bus.mem_vis_addr), 0);
    chk({tag, ":wdata"}, 64'(bus.mem_written_data), 0);
    chk({tag, ":rdata"}, 64'(bus.rdata), 0);
    chk({tag, ":rdata_valid"}, 64'(bus.rdata_valid), 0);
    chk({tag, ":beat_idx"}, 64'(bus.beat_idx), 0);
    chk({tag, ":d_beat_idx"}, 64'(bus.d_beat_idx), 0);
    chk({tag, ":i_done"}, 64'(bus.i_done), 0);
    chk({tag, ":d_done"}, 64'(bus.d_done), 0);
  endtask

  // One burst from one requester; expectations come from address arithmetic.
  task automatic run_burst(input string tag, input bit is_d, input bit we,
                           input logic [AW-1:0] addr, input logic [EIS:0] len,
                           input logic [2:0] dt, input bit scramble);
    int nb;
    bit wr, got, was_d;
    logic [AW-1:0] ea;
    nb = (len == 0) ? 1 : int'(len);
    wr = is_d && we;
    iss_q.delete();
    rv_q.delete();
    i_done_cnt = 0;
    d_done_cnt = 0;
    owner_is_d = is_d;
    if (is_d) begin
      bus.d_we = we; bus.d_addr = addr; bus.d_length = len; bus.d_data_type = dt; bus.d_req = 1'b1;
    end else begin
      bus.i_addr = addr; bus.i_length = len; bus.i_req = 1'b1;
    end
    if (scramble) begin
      repeat (2) @(negedge clk);
      bus.i_addr = AW'($urandom);
      bus.d_addr = AW'($urandom);
      bus.i_length = (EIS+1)'($urandom);
      bus.d_length = (EIS+1)'($urandom);
      bus.d_we = ~we;
      bus.d_data_type = 3'($urandom);
    end
    wait_any_done(got, was_d);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    chk({tag, ":done_seen"}, 64'(got), 1);
    mdl_streak = is_d ? mdl_streak + 1 : 0;
    repeat (3) @(negedge clk);
    chk({tag, ":i_done_cnt"}, 64'(i_done_cnt), is_d ? 0 : 1);
    chk({tag, ":d_done_cnt"}, 64'(d_done_cnt), is_d ? 1 : 0);
    chk({tag, ":issues"}, 64'(iss_q.size()), 64'(nb));
    for (int b = 0; b < nb && b < iss_q.size(); b++) begin
      ea = addr + AW'(4 * b);
      chk($sformatf("%s:addr[%0d]", tag, b), 64'(iss_q[b].addr), 64'(ea));
      chk($sformatf("%s:cmd[%0d]", tag, b), 64'(iss_q[b].sig), wr ? 64'(MEM_WRITE) : 64'(MEM_READ));
      if (wr) begin
        chk($sformatf("%s:wdata[%0d]", tag, b), 64'(iss_q[b].wdata), 64'(wdata_tbl[b]));
        chk($sformatf("%s:dtype[%0d]", tag, b), 64'(iss_q[b].dtype), 64'(dt));
        chk($sformatf("%s:d_beat_idx[%0d]", tag, b), 64'(iss_q[b].dbi), 64'(b));
      end
    end
    chk({tag, ":rvalid_cnt"}, 64'(rv_q.size()), wr ? 0 : 64'(nb));
    for (int b = 0; b < nb && b < rv_q.size(); b++) begin
      ea = addr + AW'(4 * b);
      chk($sformatf("%s:beat_idx[%0d]", tag, b), 64'(rv_q[b].idx), 64'(b));
      chk($sformatf("%s:rdata[%0d]", tag, b), 64'(rv_q[b].data), 64'(mem_word(ea)));
    end
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  initial begin : stim
    bit got, was_d, pred_d, i_pending, found;
    int n;
    logic [2:0] types [3];
    types[0] = ONE_BYTE; types[1] = TWO_BYTE; types[2] = FOUR_BYTE;
    for (int k = 0; k < 8; k++) wdata_tbl[k] = '0;
    rst_n = 1'b0;
    bus.i_req = 0; bus.i_addr = '0; bus.i_length = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_length = '0; bus.d_data_type = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("in_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_outputs_zero("after_reset");

    run_burst("inst4", 0, 0, 17'h00100, 4, '0, 0);

    // arbitration: data held continuously, one fetch waiting
    wdata_tbl[0] = 32'h0;
    bus.d_we = 0; bus.d_addr = 17'h04000; bus.d_length = 1; bus.d_data_type = '0;
    bus.i_addr = 17'h08000; bus.i_length = 1;
    i_pending = 1'b1;
    owner_is_d = (mdl_streak >= MAXS) ? 1'b0 : 1'b1;
    bus.d_req = 1'b1;
    bus.i_req = 1'b1;
    for (int g = 0; g < 6; g++) begin
      pred_d = i_pending ? (mdl_streak < MAXS) : 1'b1;
      wait_any_done(got, was_d);
      chk($sformatf("arb:done_seen[%0d]", g), 64'(got), 1);
      chk($sformatf("arb:grant_is_d[%0d]", g), 64'(was_d), 64'(pred_d));
      if (pred_d) mdl_streak++;
      else begin
        mdl_streak = 0;
        i_pending = 1'b0;
        bus.i_req = 1'b0;
      end
      if (g == 5) bus.d_req = 1'b0;
      owner_is_d = i_pending ? (mdl_streak < MAXS) : 1'b1;
    end
    repeat (6) @(negedge clk);

    wdata_tbl[0] = 32'hAABBCCDD;
    wdata_tbl[1] = 32'h11223344;
    run_burst("wr2", 1, 1, 17'h01000, 2, FOUR_BYTE, 0);

    force_noise = 1'b1;
    run_burst("noise", 0, 0, 17'h00400, 1, '0, 0);
    run_burst("noise_d", 1, 0, 17'h00800, 2, '0, 0);
    force_noise = 1'b0;

    run_burst("len0", 1, 0, 17'h02000, 0, '0, 0);
    run_burst("wrap", 0, 0, 17'h1FFFC, 2, '0, 0);

    // reset in WAIT of the second of four beats
    iss_q.delete(); rv_q.delete();
    owner_is_d = 1'b0;
    bus.i_addr = 17'h00200; bus.i_length = 4; bus.i_req = 1'b1;
    n = 0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.mem_vis_signal != MEM_NOP) begin
        n++;
        if (n == 2) begin found = 1'b1; break; end
      end
    end
    chk("rst_mid:second_issue", 64'(found), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    bus.i_req = 1'b0;
    #1 chk_outputs_zero("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    i_done_cnt = 0;
    d_done_cnt = 0;
    mdl_streak = 0;
    repeat (8) @(negedge clk);
    chk("rst_mid:no_i_done", 64'(i_done_cnt), 0);
    chk("rst_mid:no_d_done", 64'(d_done_cnt), 0);
    run_burst("after_rst", 0, 0, 17'h00300, 3, '0, 0);

    // randomized bursts, request fields sometimes garbled after grant
    for (int t = 0; t < 24; t++) begin
      for (int k = 0; k < 8; k++) wdata_tbl[k] = $urandom;
      run_burst($sformatf("rnd%0d", t), 1'($urandom), 1'($urandom), AW'($urandom),
                (EIS+1)'($urandom_range(0, 8)), types[$urandom_range(0, 2)],
                1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
